// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the 32x32 register file
`timescale 1ns/1ps
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG  = 5'd0;
    localparam logic [DATA_W-1:0] RESET_VAL = 32'h0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: mux, r0 forced to zero, optional write bypass
//
// Ports:
//   rst_i   reset; forces the port output to zero while high
//   rn_i    read register number
//   regs_i  flattened storage r1..r31 (no r0 entry)
//   we_i    write enable          (REGFILE_BYPASS_EN only)
//   wn_i    write register number (REGFILE_BYPASS_EN only)
//   d_i     write data            (REGFILE_BYPASS_EN only)
//   q_o     read data
// Macro: REGFILE_BYPASS_EN adds same-cycle forwarding of the write data.
`timescale 1ns/1ps
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic                             rst_i,
    input  logic [ADDR_W-1:0]                rn_i,
    input  logic [NUM_REGS-1:1][DATA_W-1:0]  regs_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                wn_i,
    input  logic [DATA_W-1:0]                d_i,
`endif
    output logic [DATA_W-1:0]                q_o
);

    always_comb begin
        q_o = RESET_VAL;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rn_i == ADDR_W'(i)) begin
                q_o = regs_i[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (we_i && (wn_i == rn_i)) begin
            q_o = d_i;
        end
`endif
        // Applied last so neither reset nor bypass can ever expose a non-zero r0.
        if (rst_i || (rn_i == ZERO_REG)) begin
            q_o = RESET_VAL;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 31 x 32-bit register file (r0 hardwired zero), one write port, two read ports
//
// Ports:
//   clk  clock; writes on rising edge
//   rst  asynchronous active-high reset, clears r1..r31
//   we   write enable
//   wn   write register number (writes to r0 are dropped)
//   d    write data
//   rna  read port A register number
//   rnb  read port B register number
//   qa   read port A data (combinational)
//   qb   read port B data (combinational)
// Macro: REGFILE_BYPASS_EN forwards d to a read port whose address matches wn while we is high.
`timescale 1ns/1ps
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    // Index 0 deliberately absent: r0 has no storage.
    logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;

    // Decode starts at 1, so wn == 0 never matches; we gates the compare so an
    // undefined wn cannot select a register while we is low.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (we && (wn == ADDR_W'(i))) begin
                regs_d[i] = d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= {(NUM_REGS-1){RESET_VAL}};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rdport u_rdport_a (
        .rst_i  (rst),
        .rn_i   (rna),
        .regs_i (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we_i   (we),
        .wn_i   (wn),
        .d_i    (d),
`endif
        .q_o    (qa)
    );

    regfile_rdport u_rdport_b (
        .rst_i  (rst),
        .rn_i   (rnb),
        .regs_i (regs_q),
`ifdef REGFILE_BYPASS_EN
        .we_i   (we),
        .wn_i   (wn),
        .d_i    (d),
`endif
        .q_o    (qb)
    );

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile
`timescale 1ns/1ps
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .wn  (wn),
        .d   (d),
        .rna (rna),
        .rnb (rnb),
        .qa  (qa),
        .qb  (qb)
    );

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; wn = 5'd0; d = 32'h0; rna = 5'd0; rnb = 5'd0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i); rnb = 5'(31 - i);
            #1;
            total_cnt++;
            if (qa !== 32'h0) $display("FAIL reset_qa addr=%0d got=%h exp=%h", i, qa, 32'h0);
            else pass_cnt++;
            total_cnt++;
            if (qb !== 32'h0) $display("FAIL reset_qb addr=%0d got=%h exp=%h", 31 - i, qb, 32'h0);
            else pass_cnt++;
        end
        // write edge while reset is held must be ignored
        @(negedge clk);
        we = 1'b1; wn = 5'd3; d = 32'hCAFEF00D; rna = 5'd3; rnb = 5'd3;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'h0) $display("FAIL reset_wins got=%h exp=%h", qa, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i); rnb = 5'(i);
            #1;
            total_cnt++;
            if (qa !== 32'h0 || qb !== 32'h0)
                $display("FAIL post_reset addr=%0d got=%h/%h exp=%h", i, qa, qb, 32'h0);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        we = 1'b1; wn = 5'd5; d = 32'hDEADBEEF;
        @(negedge clk);
        wn = 5'd31; d = 32'h12345678;
        @(negedge clk);
        we = 1'b0; rna = 5'd5; rnb = 5'd31;
        #1;
        total_cnt++;
        if (qa !== 32'hDEADBEEF) $display("FAIL write_r5 got=%h exp=%h", qa, 32'hDEADBEEF);
        else pass_cnt++;
        total_cnt++;
        if (qb !== 32'h12345678) $display("FAIL write_r31 got=%h exp=%h", qb, 32'h12345678);
        else pass_cnt++;
        // we low with a junk address must not disturb anything
        wn = 'x; d = 32'h0BADF00D;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'hDEADBEEF || qb !== 32'h12345678)
            $display("FAIL we_low_hold got=%h/%h exp=%h/%h", qa, qb, 32'hDEADBEEF, 32'h12345678);
        else pass_cnt++;
    endtask

    task automatic test_r0_write();
        @(negedge clk);
        we = 1'b1; wn = 5'd0; d = 32'hFFFFFFFF; rna = 5'd0; rnb = 5'd5;
        #1;
        total_cnt++;
        if (qa !== 32'h0) $display("FAIL r0_before got=%h exp=%h", qa, 32'h0);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'h0) $display("FAIL r0_after got=%h exp=%h", qa, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (qb !== 32'hDEADBEEF) $display("FAIL r0_no_side_effect got=%h exp=%h", qb, 32'hDEADBEEF);
        else pass_cnt++;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_pre;
        exp_pre = BYP ? 32'hA5A5A5A5 : 32'h0;
        @(negedge clk);
        we = 1'b1; wn = 5'd7; d = 32'hA5A5A5A5; rna = 5'd7; rnb = 5'd5;
        #1;
        total_cnt++;
        if (qa !== exp_pre) $display("FAIL same_cycle_pre got=%h exp=%h", qa, exp_pre);
        else pass_cnt++;
        total_cnt++;
        if (qb !== 32'hDEADBEEF) $display("FAIL same_cycle_other got=%h exp=%h", qb, 32'hDEADBEEF);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'hA5A5A5A5) $display("FAIL same_cycle_post got=%h exp=%h", qa, 32'hA5A5A5A5);
        else pass_cnt++;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_we_and_async_reset();
        @(negedge clk);
        we = 1'b0; wn = 5'd9; d = 32'h00000042; rna = 5'd9; rnb = 5'd9;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'h0) $display("FAIL we_low_r9 got=%h exp=%h", qa, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        we = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (qa !== 32'h00000042) $display("FAIL we_high_r9 got=%h exp=%h", qa, 32'h00000042);
        else pass_cnt++;
        total_cnt++;
        if (qb !== qa) $display("FAIL same_addr_r9 got=%h exp=%h", qb, qa);
        else pass_cnt++;
        @(negedge clk);
        we = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (qa !== 32'h0) $display("FAIL async_reset_r9 got=%h exp=%h", qa, 32'h0);
        else pass_cnt++;
        rna = 5'd5; rnb = 5'd31;
        #1;
        total_cnt++;
        if (qa !== 32'h0 || qb !== 32'h0)
            $display("FAIL async_reset_r5_r31 got=%h/%h exp=%h", qa, qb, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (qb !== 32'h0) $display("FAIL reset_cleared_r31 got=%h exp=%h", qb, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] mdl [32];
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            we  = 1'($urandom_range(0, 1));
            wn  = 5'($urandom);
            d   = $urandom;
            rna = 5'($urandom);
            rnb = ($urandom_range(0, 3) == 0) ? rna : 5'($urandom);
            #1;
            exp_a = (rna == 5'd0) ? 32'h0 : ((BYP && we && wn == rna) ? d : mdl[rna]);
            exp_b = (rnb == 5'd0) ? 32'h0 : ((BYP && we && wn == rnb) ? d : mdl[rnb]);
            total_cnt++;
            if (qa !== exp_a) $display("FAIL rand_qa cyc=%0d rna=%0d got=%h exp=%h", n, rna, qa, exp_a);
            else pass_cnt++;
            total_cnt++;
            if (qb !== exp_b) $display("FAIL rand_qb cyc=%0d rnb=%0d got=%h exp=%h", n, rnb, qb, exp_b);
            else pass_cnt++;
            if (rna == rnb) begin
                total_cnt++;
                if (qa !== qb) $display("FAIL rand_qa_eq_qb cyc=%0d got=%h exp=%h", n, qb, qa);
                else pass_cnt++;
            end
            @(posedge clk);
            if (we && wn != 5'd0) mdl[wn] = d;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_r0_write();
        test_same_cycle();
        test_we_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
